// File: rtl/frg_resp_misr.sv
// Response compactor for frg1: folds {f2,f1,f0} beats into a MISR, counts them,
// and flags pass when the held signature matches the golden value.
module frg_resp_misr #(
  parameter int unsigned        RESP_W = 3,
  parameter int unsigned        SIG_W  = 16,
  parameter logic [SIG_W-1:0]   POLY   = 16'h1021,
  parameter logic [SIG_W-1:0]   SEED   = 16'hFFFF,
  parameter int unsigned        CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [SIG_W-1:0]  golden_sig,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [RESP_W-1:0] resp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  pat_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q;
  logic             ready_q, busy_q, done_q;
  logic             hs;

  assign hs = resp_valid && ready_q;

  always_comb begin
    sig_d = {sig_q[SIG_W-2:0], 1'b0}
          ^ (sig_q[SIG_W-1] ? POLY : '0)
          ^ {{(SIG_W-RESP_W){1'b0}}, resp_data};
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sig_q    <= SEED;
      cnt_q    <= '0;
      target_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (clear) begin
      state_q  <= IDLE;
      sig_q    <= SEED;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            target_q <= num_patterns;
            sig_q    <= SEED;
            cnt_q    <= '0;
            if (num_patterns != '0) begin
              state_q <= RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            // Exit on equality with the latched target so the counter never wraps
            if (cnt_d == target_q) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign signature  = sig_q;
  assign pat_count  = cnt_q;
  assign pass       = done_q && (sig_q == golden_sig);

endmodule

// File: tb/tb_frg_resp_misr.sv
// Directed bench for frg_resp_misr: vector table of complete runs plus
// hand-written stall, clear, reset and restart sequences.
module tb_frg_resp_misr;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic [31:0] num_patterns;
  logic [15:0] golden_sig;
  logic        resp_valid;
  logic        resp_ready;
  logic [2:0]  resp_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [31:0] pat_count;

  int n_tests = 0;
  int n_fail  = 0;

  frg_resp_misr #(
    .RESP_W(3),
    .SIG_W (16),
    .POLY  (16'h1021),
    .SEED  (16'hFFFF),
    .CNT_W (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clear       (clear),
    .num_patterns(num_patterns),
    .golden_sig  (golden_sig),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .signature   (signature),
    .pat_count   (pat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [11:0] beats;   // beat i at [3*i +: 3]
    logic [15:0] golden;
    logic [15:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input int n);
    num_patterns = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_beat(input logic [2:0] d);
    resp_valid = 1'b1;
    resp_data  = d;
    tick();
    resp_valid = 1'b0;
    resp_data  = 3'b111;
  endtask

  initial begin
    logic [2:0] b;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; num_patterns = '0;
    golden_sig = 16'hFFFF; resp_valid = 1'b0; resp_data = '0;

    vecs[0] = '{n: 1, beats: 12'o0005, golden: 16'hEFDA, exp_sig: 16'hEFDA, exp_pass: 1'b1};
    vecs[1] = '{n: 2, beats: 12'o0005, golden: 16'hCF95, exp_sig: 16'hCF95, exp_pass: 1'b1};
    vecs[2] = '{n: 2, beats: 12'o0005, golden: 16'hCF94, exp_sig: 16'hCF95, exp_pass: 1'b0};
    vecs[3] = '{n: 3, beats: 12'o0127, golden: 16'h8F06, exp_sig: 16'h8F06, exp_pass: 1'b1};
    vecs[4] = '{n: 1, beats: 12'o0000, golden: 16'hEFDA, exp_sig: 16'hEFDF, exp_pass: 1'b0};
    vecs[5] = '{n: 0, beats: 12'o0000, golden: 16'hFFFF, exp_sig: 16'hFFFF, exp_pass: 1'b1};

    // Reset state; pass stays low outside DONE even when golden matches SEED
    @(negedge clk);
    chk("rst_sig",   signature,  16'hFFFF);
    chk("rst_cnt",   pat_count,  0);
    chk("rst_ready", resp_ready, 0);
    chk("rst_busy",  busy,       0);
    chk("rst_done",  done,       0);
    chk("rst_pass",  pass,       0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      golden_sig = vecs[v].golden;
      do_start(vecs[v].n);
      for (int i = 0; i < vecs[v].n; i++) begin
        chk($sformatf("v%0d_ready%0d", v, i), resp_ready, 1);
        chk($sformatf("v%0d_done_early%0d", v, i), done, 0);
        b = vecs[v].beats[3*i +: 3];
        do_beat(b);
        chk($sformatf("v%0d_cnt%0d", v, i), pat_count, i + 1);
      end
      chk($sformatf("v%0d_sig", v),   signature,  {16'h0, vecs[v].exp_sig});
      chk($sformatf("v%0d_cnt", v),   pat_count,  vecs[v].n);
      chk($sformatf("v%0d_done", v),  done,       1);
      chk($sformatf("v%0d_busy", v),  busy,       0);
      chk($sformatf("v%0d_ready", v), resp_ready, 0);
      chk($sformatf("v%0d_pass", v),  pass,       {31'h0, vecs[v].exp_pass});
      // DONE holds while upstream keeps offering data
      resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0;
      chk($sformatf("v%0d_hold", v), signature, {16'h0, vecs[v].exp_sig});
    end

    // Stall between beats; num_patterns changed mid-run must not move the target
    golden_sig = 16'hCF95;
    do_start(2);
    num_patterns = 1;
    do_beat(3'b101);
    chk("stall_sig1", signature, 16'hEFDA);
    for (int i = 0; i < 5; i++) begin
      resp_data = 3'b011;
      tick();
    end
    chk("stall_sig_hold", signature, 16'hEFDA);
    chk("stall_cnt_hold", pat_count, 1);
    chk("stall_busy",     busy,      1);
    do_beat(3'b000);
    chk("stall_sig2", signature, 16'hCF95);
    chk("stall_done", done,      1);
    chk("stall_pass", pass,      1);

    // clear together with a valid beat mid-run
    do_start(2);
    do_beat(3'b101);
    clear = 1'b1; resp_valid = 1'b1; resp_data = 3'b111;
    tick();
    clear = 1'b0;
    chk("clr_sig",   signature,  16'hFFFF);
    chk("clr_cnt",   pat_count,  0);
    chk("clr_ready", resp_ready, 0);
    chk("clr_busy",  busy,       0);
    chk("clr_done",  done,       0);
    tick();
    resp_valid = 1'b0;
    chk("clr_idle_sig", signature, 16'hFFFF);

    // Asynchronous reset mid-run, observed before any clock edge
    do_start(2);
    do_beat(3'b101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sig",  signature, 16'hFFFF);
    chk("arst_cnt",  pat_count, 0);
    chk("arst_busy", busy,      0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_idle_done", done, 0);

    // Restart from DONE re-seeds; start pulsed in RUN is ignored
    golden_sig = 16'hEFDA;
    do_start(1);
    do_beat(3'b000);
    chk("re_first", signature, 16'hEFDF);
    do_start(1);
    chk("re_seed", signature, 16'hFFFF);
    chk("re_busy", busy, 1);
    do_beat(3'b101);
    chk("re_sig",  signature, 16'hEFDA);
    chk("re_pass", pass, 1);

    do_start(2);
    do_beat(3'b101);
    do_start(0);
    chk("ign_busy", busy,      1);
    chk("ign_cnt",  pat_count, 1);
    chk("ign_sig",  signature, 16'hEFDA);
    do_beat(3'b000);
    chk("ign_final", signature, 16'hCF95);
    chk("ign_done",  done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
